regfile_decode_hz: RTL and testbench

Parametrised decode-stage register file for the pipelined MIPS core. It provides two combinational read ports, a decoupled write-back port with same-cycle bypass, and a valid/ready injection port for the external I/O register. A load scoreboard raises a hazard when a source register awaits memory data. It also generates the destination address and the extended immediate for the instruction in decode.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/regfile_decode_hz_if.sv | 22 ++
 rtl/imm_ext.sv | 21 ++
 rtl/regfile_decode_hz.sv | 100 ++++++++++
 tb/tb_regfile_decode_hz.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode, field and immediate-mode definitions
package mips_pkg;

    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam int REG_RA = 31;

    typedef enum logic [1:0] {
        EXT_SIGN,
        EXT_ZERO,
        EXT_LUI
    } ext_mode_e;

    function automatic ext_mode_e ext_mode(input logic [5:0] op);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: return EXT_ZERO;
            OP_LUI:                   return EXT_LUI;
            default:                  return EXT_SIGN;
        endcase
    endfunction

endpackage

// File: rtl/regfile_decode_hz_if.sv
// rtl/regfile_decode_hz_if.sv - write-back and external injection port bundle
interface regfile_decode_hz_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ext_valid;
    logic [DATA_W-1:0] ext_data;
    logic              ext_ready;

    modport master (
        output wb_en, wb_addr, wb_data, ext_valid, ext_data,
        input  ext_ready
    );

    modport slave (
        input  wb_en, wb_addr, wb_data, ext_valid, ext_data,
        output ext_ready
    );
endinterface

// File: rtl/imm_ext.sv
// rtl/imm_ext.sv - combinational immediate extender selected by opcode
module imm_ext
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        opcode,
    input  logic [15:0]       imm,
    output logic [DATA_W-1:0] imme_extend
);

    always_comb begin
        imme_extend = '0;
        case (ext_mode(opcode))
            EXT_ZERO: imme_extend[15:0] = imm;
            EXT_LUI:  imme_extend[31:16] = imm;
            default:  imme_extend = {{(DATA_W-16){imm[15]}}, imm};
        endcase
    end

endmodule

// File: rtl/regfile_decode_hz.sv
// rtl/regfile_decode_hz.sv - decode-stage register file with bypass, load scoreboard and I/O injection
module regfile_decode_hz
    import mips_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  NREGS  = 32,
    parameter int  IO_REG = 25,
    parameter int  BYPASS = 1,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic              jal,
    input  logic              reg_dst,
    input  logic              ld_issue,
    output logic [ADDR_W-1:0] dest_addr,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic [DATA_W-1:0] imme_extend,
    output logic              hazard,
    regfile_decode_hz_if.slave bus,
    output logic [DATA_W-1:0] io_reg_o
);

    localparam logic [ADDR_W-1:0] IO_A = ADDR_W'(IO_REG);
    localparam logic [ADDR_W-1:0] RA_A = ADDR_W'(REG_RA);
    localparam bit                BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;

    logic [ADDR_W-1:0] rs_a, rt_a, rd_a;
    logic              ext_acc;
    logic              wb_live;

    assign rs_a = ADDR_W'(instruction[RS_MSB:RS_LSB]);
    assign rt_a = ADDR_W'(instruction[RT_MSB:RT_LSB]);
    assign rd_a = ADDR_W'(instruction[RD_MSB:RD_LSB]);

    assign dest_addr = jal ? RA_A : (reg_dst ? rd_a : rt_a);

    imm_ext #(.DATA_W(DATA_W)) u_imm_ext (
        .opcode      (instruction[OP_MSB:OP_LSB]),
        .imm         (instruction[IMM_MSB:IMM_LSB]),
        .imme_extend (imme_extend)
    );

    // Core write-back always wins the IO register; injection waits a cycle.
    assign bus.ext_ready = !reset && !(bus.wb_en && bus.wb_addr == IO_A);
    assign ext_acc       = bus.ext_valid && bus.ext_ready;
    assign wb_live       = bus.wb_en && (bus.wb_addr != '0);

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        if (BYP && wb_live && bus.wb_addr == a)
            return bus.wb_data;
        else if (BYP && ext_acc && a == IO_A)
            return bus.ext_data;
        else
            return regs[a];
    endfunction

    assign read_data_1 = read_port(rs_a);
    assign read_data_2 = read_port(rt_a);
    assign io_reg_o    = regs[IO_A];

    // A load issued to the register being written back stays pending.
    always_comb begin
        busy_nxt = busy;
        if (bus.wb_en)
            busy_nxt[bus.wb_addr] = 1'b0;
        if (ld_issue)
            busy_nxt[dest_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wb_live)
                regs[bus.wb_addr] <= bus.wb_data;
            if (ext_acc)
                regs[IO_A] <= bus.ext_data;
            busy <= busy_nxt;
        end
    end

    always_comb begin
        if (BYP)
            hazard = (busy[rs_a] && !(bus.wb_en && bus.wb_addr == rs_a)) ||
                     (busy[rt_a] && !(bus.wb_en && bus.wb_addr == rt_a));
        else
            hazard = busy[rs_a] || busy[rt_a];
    end

endmodule

// File: tb/tb_regfile_decode_hz.sv
// tb/tb_regfile_decode_hz.sv - directed self-checking bench for regfile_decode_hz (bypass on and off)
module tb_regfile_decode_hz;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        jal, reg_dst, ld_issue;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ext_valid;
    logic [31:0] ext_data;

    logic [4:0]  dest_a, dest_b;
    logic [31:0] rd1_a, rd2_a, imm_a, io_a;
    logic [31:0] rd1_b, rd2_b, imm_b, io_b;
    logic        hz_a, hz_b;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    regfile_decode_hz_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
    regfile_decode_hz_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

    assign bus_a.wb_en     = wb_en;
    assign bus_a.wb_addr   = wb_addr;
    assign bus_a.wb_data   = wb_data;
    assign bus_a.ext_valid = ext_valid;
    assign bus_a.ext_data  = ext_data;
    assign bus_b.wb_en     = wb_en;
    assign bus_b.wb_addr   = wb_addr;
    assign bus_b.wb_data   = wb_data;
    assign bus_b.ext_valid = ext_valid;
    assign bus_b.ext_data  = ext_data;

    regfile_decode_hz #(.DATA_W(32), .NREGS(32), .IO_REG(25), .BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .instruction(instruction),
        .jal(jal), .reg_dst(reg_dst), .ld_issue(ld_issue),
        .dest_addr(dest_a), .read_data_1(rd1_a), .read_data_2(rd2_a),
        .imme_extend(imm_a), .hazard(hz_a), .bus(bus_a), .io_reg_o(io_a)
    );

    regfile_decode_hz #(.DATA_W(32), .NREGS(32), .IO_REG(25), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .instruction(instruction),
        .jal(jal), .reg_dst(reg_dst), .ld_issue(ld_issue),
        .dest_addr(dest_b), .read_data_1(rd1_b), .read_data_2(rd2_b),
        .imme_extend(imm_b), .hazard(hz_b), .bus(bus_b), .io_reg_o(io_b)
    );

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 11'h000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1; instruction = '0; jal = 1'b0; reg_dst = 1'b0; ld_issue = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; ext_valid = 1'b1; ext_data = 32'hDEAD_BEEF;
        tick(); settle();
        chk("ext_ready_in_reset", {31'b0, bus_a.ext_ready}, 32'h0);
        tick();
        reset = 1'b0; ext_valid = 1'b0;
        instruction = r_type(5'd5, 5'd25, 5'd0);
        settle();
        chk("reset_rd1", rd1_a, 32'h0);
        chk("reset_io_reg", io_a, 32'h0);
        chk("reset_hazard", {31'b0, hz_a}, 32'h0);

        // write-back to r5 with same-cycle read
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
        settle();
        chk("bypass_rd1", rd1_a, 32'h1234_5678);
        chk("nobypass_rd1_same", rd1_b, 32'h0);
        tick(); wb_en = 1'b0; settle();
        chk("after_wb_rd1", rd1_a, 32'h1234_5678);
        chk("nobypass_rd1_next", rd1_b, 32'h1234_5678);

        // write to r0 is dropped
        instruction = r_type(5'd0, 5'd5, 5'd0);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
        settle();
        chk("r0_bypass", rd1_a, 32'h0);
        tick(); wb_en = 1'b0; settle();
        chk("r0_after", rd1_a, 32'h0);
        chk("rd2_r5", rd2_a, 32'h1234_5678);

        // injection collides with core write-back to r25
        instruction = r_type(5'd25, 5'd0, 5'd0);
        ext_valid = 1'b1; ext_data = 32'h0000_00AA;
        wb_en = 1'b1; wb_addr = 5'd25; wb_data = 32'h0000_0055;
        settle();
        chk("ext_ready_blocked", {31'b0, bus_a.ext_ready}, 32'h0);
        chk("collide_rd1", rd1_a, 32'h0000_0055);
        tick(); wb_en = 1'b0; settle();
        chk("io_after_wb", io_a, 32'h0000_0055);
        chk("ext_ready_free", {31'b0, bus_a.ext_ready}, 32'h1);
        chk("ext_bypass_rd1", rd1_a, 32'h0000_00AA);
        chk("ext_nobypass_rd1", rd1_b, 32'h0000_0055);
        tick(); ext_valid = 1'b0; settle();
        chk("io_after_inject", io_a, 32'h0000_00AA);
        chk("io_after_inject_b", io_b, 32'h0000_00AA);

        // load to r8 then dependent read
        instruction = i_type(6'h23, 5'd0, 5'd8, 16'h0000);
        ld_issue = 1'b1;
        settle();
        chk("ld_dest", {27'b0, dest_a}, 32'd8);
        chk("ld_no_self_hazard", {31'b0, hz_a}, 32'h0);
        tick(); ld_issue = 1'b0;
        instruction = r_type(5'd8, 5'd0, 5'd0);
        settle();
        chk("hazard_set", {31'b0, hz_a}, 32'h1);
        chk("hazard_set_b", {31'b0, hz_b}, 32'h1);
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_0077;
        settle();
        chk("hazard_release", {31'b0, hz_a}, 32'h0);
        chk("hazard_release_b", {31'b0, hz_b}, 32'h1);
        chk("release_rd1", rd1_a, 32'h0000_0077);
        tick(); wb_en = 1'b0; settle();
        chk("hazard_cleared", {31'b0, hz_a}, 32'h0);
        chk("hazard_cleared_b", {31'b0, hz_b}, 32'h0);

        // set and clear of r9 in the same cycle: set wins
        instruction = i_type(6'h23, 5'd0, 5'd9, 16'h0000);
        ld_issue = 1'b1; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0099;
        tick(); ld_issue = 1'b0; wb_en = 1'b0;
        instruction = r_type(5'd0, 5'd9, 5'd0);
        settle();
        chk("set_wins_hazard", {31'b0, hz_a}, 32'h1);
        chk("set_wins_rd2", rd2_a, 32'h0000_0099);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0100;
        tick(); wb_en = 1'b0; settle();
        chk("r9_released", {31'b0, hz_a}, 32'h0);

        // immediates
        instruction = i_type(6'h0D, 5'd0, 5'd1, 16'h8001); settle();
        chk("imm_ori", imm_a, 32'h0000_8001);
        instruction = i_type(6'h08, 5'd0, 5'd1, 16'h8001); settle();
        chk("imm_addi", imm_a, 32'hFFFF_8001);
        instruction = i_type(6'h0F, 5'd0, 5'd1, 16'h8001); settle();
        chk("imm_lui", imm_a, 32'h8001_0000);
        chk("imm_lui_b", imm_b, 32'h8001_0000);
        instruction = i_type(6'h0C, 5'd0, 5'd1, 16'hF00F); settle();
        chk("imm_andi", imm_a, 32'h0000_F00F);

        // destination select
        instruction = {6'h03, 26'h0000_123}; jal = 1'b1; settle();
        chk("dest_jal", {27'b0, dest_a}, 32'd31);
        jal = 1'b0; reg_dst = 1'b1;
        instruction = r_type(5'd3, 5'd4, 5'd12); settle();
        chk("dest_rd", {27'b0, dest_a}, 32'd12);

        // busy r12, then reset with a competing load issue
        ld_issue = 1'b1;
        tick();
        instruction = r_type(5'd12, 5'd5, 5'd12);
        settle();
        chk("hazard_r12", {31'b0, hz_a}, 32'h1);
        reset = 1'b1;
        tick(); settle();
        chk("reset_hazard_r12", {31'b0, hz_a}, 32'h0);
        chk("reset_rd2_r5", rd2_a, 32'h0);
        chk("reset_io", io_a, 32'h0);
        reset = 1'b0; ld_issue = 1'b0; reg_dst = 1'b0;
        settle();
        chk("post_reset_hazard", {31'b0, hz_a}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
